md_unit: RTL

Iterative multiply/divide sequencer that sits beside the EX-stage ALU in the pipelined MIPS CPU and owns the HI/LO registers. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from EX. It runs a 32-step shift-add or restoring-divide sequence and holds `busy` so the hazard unit stalls any following HI/LO-dependent or multiply/divide instruction.

---
 rtl/md_unit_pkg.sv | 27 ++
 rtl/md_step.sv | 35 +++
 rtl/md_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared op codes, FSM state type and helpers for the
// multiply/divide sequencer.
package md_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam logic [5:0] MD_LAST_STEP = 6'd31;

  typedef enum logic [1:0] {
    MDS_IDLE = 2'd0,
    MDS_MUL  = 2'd1,
    MDS_DIV  = 2'd2,
    MDS_FIX  = 2'd3
  } md_state_e;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/md_step.sv
// md_step: one combinational iteration of the sequencer.
//   acc      : 64-bit accumulator. Multiply: {partial product, multiplier}.
//              Divide: {partial remainder, dividend/quotient bits}.
//   opnd     : multiplicand (multiply) or divisor (divide) magnitude.
//   mode     : 0 = shift-add multiply step, 1 = restoring divide step.
//   acc_next : accumulator after the step.
module md_step
  import md_unit_pkg::*;
(
  input  logic [63:0] acc,
  input  logic [31:0] opnd,
  input  logic        mode,
  output logic [63:0] acc_next
);

  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [33:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    div_shift = {acc[63:32], acc[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    acc_next  = '0;
    if (!mode) begin
      acc_next = {mul_sum, acc[31:1]};
    end else if (!div_diff[33]) begin
      // Remainder stays below the divisor, so the low 32 bits hold it.
      acc_next = {div_diff[31:0], acc[30:0], 1'b1};
    end else begin
      acc_next = {div_shift[31:0], acc[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide sequencer owning HI/LO.
//   clk, reset (sync, active-low)
//   start, MDOp, A, B : request from EX
//   busy              : high while a 32-step sequence plus FIX runs
//   HI, LO            : architectural HI/LO registers
//
// state    | meaning
// ---------+------------------------------------------------
// MDS_IDLE | waiting; accepts mult/div starts and MTHI/MTLO
// MDS_MUL  | 32 shift-add steps
// MDS_DIV  | 32 restoring-divide steps
// MDS_FIX  | sign correction and HI/LO write-back
module md_unit
  import md_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_e   state;
  logic [5:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic        neg_q;
  logic        neg_r;
  logic        is_div;
  logic        div_zero;

  logic        signed_op;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] step_out;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign signed_op = (MDOp == MD_MULT) || (MDOp == MD_DIV);
  assign a_mag     = signed_op ? abs32(A) : A;
  assign b_mag     = signed_op ? abs32(B) : B;

  assign prod_fix  = neg_q ? (~acc + 64'd1) : acc;
  assign quot_fix  = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
  assign rem_fix   = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];

  md_step u_step (
    .acc      (acc),
    .opnd     (opnd),
    .mode     (state == MDS_DIV),
    .acc_next (step_out)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= MDS_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      case (state)
        MDS_IDLE: begin
          if (start) begin
            case (MDOp)
              MD_MULT, MD_MULTU: begin
                acc      <= {32'd0, b_mag};
                opnd     <= a_mag;
                neg_q    <= signed_op & (A[31] ^ B[31]);
                neg_r    <= 1'b0;
                is_div   <= 1'b0;
                div_zero <= 1'b0;
                cnt      <= '0;
                busy     <= 1'b1;
                state    <= MDS_MUL;
              end
              MD_DIV, MD_DIVU: begin
                acc      <= {32'd0, a_mag};
                opnd     <= b_mag;
                neg_q    <= signed_op & (A[31] ^ B[31]);
                neg_r    <= signed_op & A[31];
                is_div   <= 1'b1;
                div_zero <= (B == 32'd0);
                cnt      <= '0;
                busy     <= 1'b1;
                state    <= MDS_DIV;
              end
              MD_MTHI: HI <= A;
              MD_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
        MDS_MUL, MDS_DIV: begin
          acc <= step_out;
          cnt <= cnt + 6'd1;
          if (cnt == MD_LAST_STEP) state <= MDS_FIX;
        end
        MDS_FIX: begin
          if (!is_div) begin
            HI <= prod_fix[63:32];
            LO <= prod_fix[31:0];
          end else if (!div_zero) begin
            HI <= rem_fix;
            LO <= quot_fix;
          end
          busy  <= 1'b0;
          state <= MDS_IDLE;
        end
        default: state <= MDS_IDLE;
      endcase
    end
  end

endmodule
